// File: rtl/matmul_index_downseq_if.sv
// Index-tuple stream between the down-counting matmul index sequencer and
// its consumer (typically a MAC datapath).
//   idx_valid : tuple on row/col/kk is offered
//   idx_ready : consumer accepts the offered tuple
//   row/col/kk: current index tuple, W bits each
//   first_k   : tuple is the first of an inner-product run (accumulator clear)
//   last_k    : tuple is the last of an inner-product run (accumulator write-back)
// master = sequencer side, slave = consumer side.
interface matmul_index_downseq_if #(
    parameter int W = 4
);
    logic         idx_valid;
    logic         idx_ready;
    logic [W-1:0] row;
    logic [W-1:0] col;
    logic [W-1:0] kk;
    logic         first_k;
    logic         last_k;

    modport master (
        output idx_valid,
        output row,
        output col,
        output kk,
        output first_k,
        output last_k,
        input  idx_ready
    );

    modport slave (
        input  idx_valid,
        input  row,
        input  col,
        input  kk,
        input  first_k,
        input  last_k,
        output idx_ready
    );
endinterface

// File: rtl/matmul_index_downseq.sv
// Descending (row, col, kk) index sequencer for a matrix multiply, kk innermost.
// On start the limits are latched and the sweep runs from (m_lim,n_lim,k_lim)
// down to (0,0,0), advancing one tuple per valid/ready beat.
// Ports:
//   clk      : clock, rising edge
//   clr_n    : synchronous active-low reset
//   start    : request a sweep (honoured only when idle)
//   m_lim, n_lim, k_lim : highest row / col / inner index (dimension - 1)
//   busy     : high while a sweep is running or completing
//   done     : one-cycle pulse after the final beat
//   ix       : index-tuple stream (master side)
// All outputs come straight from flops; each flag is computed from the
// next-state values so it lines up with the registered tuple.
module matmul_index_downseq #(
    parameter int W = 4
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  start,
    input  logic [W-1:0]          m_lim,
    input  logic [W-1:0]          n_lim,
    input  logic [W-1:0]          k_lim,
    output logic                  busy,
    output logic                  done,
    matmul_index_downseq_if.master ix
);

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_run  = 2'd1,
        st_done = 2'd2
    } state_t;

    localparam logic [W-1:0] idx_zero = {W{1'b0}};
    localparam logic [W-1:0] idx_one  = {{(W-1){1'b0}}, 1'b1};

    state_t       state_r, state_s;
    logic [W-1:0] row_r, row_s;
    logic [W-1:0] col_r, col_s;
    logic [W-1:0] kk_r, kk_s;
    logic [W-1:0] mlim_r, mlim_s;
    logic [W-1:0] nlim_r, nlim_s;
    logic [W-1:0] klim_r, klim_s;
    logic         valid_r, valid_s;
    logic         first_r, first_s;
    logic         last_r, last_s;
    logic         busy_s;
    logic         done_s;

    // Next-state, index counting and next-output-flag computation.
    always_comb begin
        state_s = state_r;
        row_s   = row_r;
        col_s   = col_r;
        kk_s    = kk_r;
        mlim_s  = mlim_r;
        nlim_s  = nlim_r;
        klim_s  = klim_r;
        unique case (state_r)
            st_idle: begin
                if (start) begin
                    mlim_s  = m_lim;
                    nlim_s  = n_lim;
                    klim_s  = k_lim;
                    row_s   = m_lim;
                    col_s   = n_lim;
                    kk_s    = k_lim;
                    state_s = st_run;
                end else begin
                    state_s = st_idle;
                end
            end
            st_run: begin
                // idx_valid is always high in RUN, so ready alone marks a beat.
                if (ix.idx_ready) begin
                    if ((row_r == idx_zero) && (col_r == idx_zero) && (kk_r == idx_zero)) begin
                        // Final beat: indices stay at (0,0,0) for the idle hold.
                        state_s = st_done;
                    end else if (kk_r != idx_zero) begin
                        kk_s = kk_r - idx_one;
                    end else if (col_r != idx_zero) begin
                        kk_s  = klim_r;
                        col_s = col_r - idx_one;
                    end else begin
                        // row_r cannot be zero here: that case is the final beat.
                        kk_s  = klim_r;
                        col_s = nlim_r;
                        row_s = row_r - idx_one;
                    end
                end else begin
                    state_s = st_run;
                end
            end
            st_done: begin
                state_s = st_idle;
            end
            default: begin
                state_s = st_idle;
            end
        endcase
        valid_s = (state_s == st_run);
        first_s = valid_s && (kk_s == klim_s);
        last_s  = valid_s && (kk_s == idx_zero);
        busy_s  = (state_s != st_idle);
        done_s  = (state_s == st_done);
    end

    // State, index, latched-limit and output flag registers.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_r <= st_idle;
            row_r   <= idx_zero;
            col_r   <= idx_zero;
            kk_r    <= idx_zero;
            mlim_r  <= idx_zero;
            nlim_r  <= idx_zero;
            klim_r  <= idx_zero;
            valid_r <= 1'b0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_s;
            row_r   <= row_s;
            col_r   <= col_s;
            kk_r    <= kk_s;
            mlim_r  <= mlim_s;
            nlim_r  <= nlim_s;
            klim_r  <= klim_s;
            valid_r <= valid_s;
            first_r <= first_s;
            last_r  <= last_s;
            busy    <= busy_s;
            done    <= done_s;
        end
    end

    assign ix.idx_valid = valid_r;
    assign ix.row       = row_r;
    assign ix.col       = col_r;
    assign ix.kk        = kk_r;
    assign ix.first_k   = first_r;
    assign ix.last_k    = last_r;

    // mlim_r is kept for completeness of the latched limit set; row only
    // ever counts down from its load value so it is not read back.
    logic unused_mlim_s;
    assign unused_mlim_s = ^mlim_r;

endmodule

// File: doc/matmul_index_downseq.md
MATMUL_INDEX_DOWNSEQ -- requirements
Module: matmul_index_downseq

Interface
REQ-001 The block SHALL have one parameter: W, default 4, the index width in bits (matches the 4-bit loop counters).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clr_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a new index sweep.
REQ-005 The block SHALL have ports m_lim, n_lim, k_lim, input, W bits each: the highest row, column and inner-product index (dimension minus one).
REQ-006 The block SHALL have port idx_valid, output, 1 bit: the index tuple on row/col/kk is offered.
REQ-007 The block SHALL have port idx_ready, input, 1 bit: the consumer accepts the offered tuple.
REQ-008 The block SHALL have ports row, col, kk, output, W bits each: the current index tuple.
REQ-009 The block SHALL have port first_k, output, 1 bit: high while kk == latched k_lim and idx_valid is high (accumulator clear).
REQ-010 The block SHALL have port last_k, output, 1 bit: high while kk == 0 and idx_valid is high (accumulator write-back).
REQ-011 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse at sweep completion.

Function
REQ-013 The block SHALL implement three states: IDLE, RUN, DONE.
REQ-014 IDLE: when start=1, the block SHALL latch m_lim/n_lim/k_lim and, at that edge, load row=m_lim, col=n_lim, kk=k_lim, then enter RUN.
REQ-015 The first tuple SHALL be presented with idx_valid=1 in the cycle after the start edge (1-cycle latency).
REQ-016 In RUN, idx_valid SHALL be 1 and row/col/kk/first_k/last_k SHALL remain stable while idx_ready=0.
REQ-017 A beat SHALL occur on any edge with idx_valid=1 and idx_ready=1; only beats advance the indices.
REQ-018 The count order SHALL be descending, with kk innermost: kk decrements; when kk==0, kk reloads k_lim and col decrements; when col==0 too, col reloads n_lim and row decrements.
REQ-019 The beat on tuple (0,0,0) SHALL be the final beat: idx_valid deasserts next cycle and the state goes to DONE.
REQ-020 The sweep SHALL produce exactly (m_lim+1)*(n_lim+1)*(k_lim+1) beats, with no skipped or repeated tuple.
REQ-021 Limits of 0 SHALL be legal; all-zero limits yield exactly one beat (0,0,0) carrying first_k=1 and last_k=1.
REQ-022 DONE SHALL last exactly one cycle with done=1 and then return to IDLE.
REQ-023 start SHALL be ignored in RUN and DONE, and input limit changes after the start edge SHALL have no effect.
REQ-024 No index arithmetic SHALL wrap below 0; a reload occurs instead.
REQ-025 In IDLE and DONE, idx_valid, first_k and last_k SHALL be 0.
REQ-026 In IDLE and DONE, row/col/kk SHALL hold their last value; the verifier SHALL NOT check them there.

Reset
REQ-027 While clr_n=0 at a rising edge, the block SHALL enter IDLE, set row/col/kk/latched limits to 0, and set idx_valid, busy, done, first_k and last_k to 0.
REQ-028 Reset asserted mid-RUN SHALL abort the sweep with no done pulse.
REQ-029 Reset SHALL take priority over start and over a beat in the same cycle.

Verification
REQ-030 The bench SHALL cover this scenario: limits (1,1,1), idx_ready=1 constantly, start pulse -> 8 beats in order (1,1,1),(1,1,0),(1,0,1),(1,0,0),(0,1,1),(0,1,0),(0,0,1),(0,0,0); first_k on odd-position beats, last_k on even-position beats; done one cycle after the final beat.
REQ-031 The bench SHALL cover this scenario: limits (0,0,0) -> single beat (0,0,0) with first_k=last_k=1, then done=1 for exactly one cycle, busy low the cycle after.
REQ-032 The bench SHALL cover this scenario: limits (2,0,3), idx_ready random 50% -> exactly 12 beats; tuples stable across every stall; no duplicate tuples.
REQ-033 The bench SHALL cover this scenario: second start and limit changes during RUN -> ignored; sweep completes with the originally latched limits.
REQ-034 The bench SHALL cover this scenario: clr_n=0 after the 3rd beat of a (3,3,3) sweep -> next cycle idx_valid=0, busy=0, row/col/kk=0, no done; a fresh start then restarts at (3,3,3).
REQ-035 The bench SHALL cover this scenario: limits (15,15,15) with W=4 -> 4096 beats, final tuple (0,0,0), no wrap to 15 before the end.
